// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit. One operation at a time: shift-add
//   multiply or restoring divide over XLEN cycles; divide-by-zero and signed
//   overflow are resolved in one cycle without iterating.
//
//   Optional build macro: MULDIV_FAST_MUL_EN -- multiply ops complete with a
//   single-cycle full-width product instead of iterating.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request, honoured when no operation is iterating
//   op[2:0]      funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   a, b         rs1 / rs2 operands, captured at accept
//   flush        abort in-flight operation; also blocks a same-cycle accept
//   busy         state != IDLE
//   valid        one-cycle result strobe (DONE without flush)
//   result       result, held until the next completion
//   stall        pipeline hold
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result,
   output logic            stall
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     result_q, result_d;

   // Operand decode at accept
   logic                sa, sb, a_s, b_s, neg_in, accept;
   logic                b_zero, ovf, div_spec;
   logic [XLEN-1:0]     a_mag, b_mag, spec_res;

   // Iteration datapath
   logic [XLEN:0]       mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0]   acc_next, prod_f;
   logic [XLEN-1:0]     div_pick, div_f, final_res;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN+1:0] fprod;
   logic [XLEN-1:0]          fast_res;
`endif

   always_comb begin
      sa     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      sb     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_s    = sa & a[XLEN-1];
      b_s    = sb & b[XLEN-1];
      a_mag  = a_s ? -a : a;
      b_mag  = b_s ? -b : b;
      // rem takes sign of a; everything else signs by a XOR b
      neg_in = (op[2] & op[1]) ? a_s : (a_s ^ b_s);

      b_zero   = (b == '0);
      ovf      = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      div_spec = op[2] & (b_zero | (~op[0] & ovf));
      if (b_zero) spec_res = op[1] ? a : '1;
      else        spec_res = op[1] ? '0 : a;
      accept   = (state_q != CALC) & start & ~flush;
   end

`ifdef MULDIV_FAST_MUL_EN
   always_comb begin
      fa       = {a_s, a};
      fb       = {b_s, b};
      fprod    = fa * fb;
      fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
   end
`endif

   // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient}
   // for divide, so both algorithms share one 2*XLEN shift register.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, mcand_q};
      if (op_q[2]) begin
         if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
         else                acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod_f    = neg_q ? -acc_next : acc_next;
      div_pick  = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      div_f     = neg_q ? -div_pick : div_pick;
      if (op_q[2])                final_res = div_f;
      else if (op_q[1:0] == 2'b00) final_res = prod_f[XLEN-1:0];
      else                        final_res = prod_f[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         CALC: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = acc_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) begin
                  state_d  = DONE;
                  result_d = final_res;
                  cnt_d    = '0;
               end
            end
         end
         default: begin
            // IDLE and DONE: DONE always leaves; either may accept a new op
            state_d = IDLE;
            if (accept) begin
               op_d  = op;
               neg_d = neg_in;
               cnt_d = '0;
               if (div_spec) begin
                  state_d  = DONE;
                  result_d = spec_res;
`ifdef MULDIV_FAST_MUL_EN
               end else if (!op[2]) begin
                  state_d  = DONE;
                  result_d = fast_res;
`endif
               end else begin
                  state_d = CALC;
                  acc_d   = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                  mcand_d = op[2] ? b_mag : a_mag;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign valid  = (state_q == DONE) & ~flush;
   assign stall  = ((state_q == IDLE) & start & ~flush) | (state_q == CALC);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy, valid, stall;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .valid(valid), .result(result), .stall(stall)
   );

   always #5 clk = ~clk;

   // Issue one op and wait (bounded) for valid; lat counts cycles after accept.
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit stall_ok);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      stall_ok = 1'b1;
      while (!valid && lat < 100) begin
         if (!stall) stall_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({busy, valid, stall} !== 3'b000 || result !== 32'h0) begin
         fails++;
         $display("FAIL reset: busy/valid/stall=%b result=%h, required 000 / 00000000",
                  {busy, valid, stall}, result);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] r; int lat; bit sok;
      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, sok);
      tests++;
      if (r !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result: got %h required FFFFFFEB", r); end
      tests++;
      if (lat !== MUL_LAT) begin fails++; $display("FAIL mul_latency: got %0d required %0d", lat, MUL_LAT); end
      tests++;
      if (!sok) begin fails++; $display("FAIL mul_stall: stall dropped before valid, required high"); end
      @(negedge clk);
      tests++;
      if ({valid, busy} !== 2'b00 || result !== 32'hFFFF_FFEB) begin
         fails++;
         $display("FAIL mul_after: valid/busy=%b result=%h, required 00 / FFFFFFEB", {valid, busy}, result);
      end
   endtask

   task automatic test_mul_high();
      logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] av  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bv  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
      logic [31:0] ex  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] r; int lat; bit sok;
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i], av[i], bv[i], r, lat, sok);
         tests++;
         if (r !== ex[i] || lat !== MUL_LAT) begin
            fails++;
            $display("FAIL mulhi_%0d: got %h lat %0d, required %h lat %0d", i, r, lat, ex[i], MUL_LAT);
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
      logic [31:0] av  [4] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] bv  [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
      logic [31:0] ex  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] r; int lat; bit sok;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], av[i], bv[i], r, lat, sok);
         tests++;
         if (r !== ex[i] || lat !== 33 || !sok) begin
            fails++;
            $display("FAIL div_%0d: got %h lat %0d stall_ok %0d, required %h lat 33 stall_ok 1",
                     i, r, lat, sok, ex[i]);
         end
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [31:0] r; int lat; bit sok;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], av[i], bv[i], r, lat, sok);
         tests++;
         if (r !== ex[i] || lat !== 1) begin
            fails++;
            $display("FAIL special_%0d: got %h lat %0d, required %h lat 1", i, r, lat, ex[i]);
         end
      end
   endtask

   // divu 100/7 with a competing mul request held while busy
   task automatic test_busy_start();
      int lat;
      @(negedge clk);
      op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = 3'b000; a = 32'd3; b = 32'd3;
      lat = 1;
      while (!valid && lat < 100) begin
         if (lat == 5) start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      tests++;
      if (result !== 32'd14 || lat !== 33) begin
         fails++;
         $display("FAIL busy_start: got %h lat %0d, required 0000000e lat 33", result, lat);
      end
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      op = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      tests++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL flush_pre: valid=%b busy=%b, required 0 1", valid, busy);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({busy, valid, stall} !== 3'b000 || result !== 32'd14) begin
         fails++;
         $display("FAIL flush_post: busy/valid/stall=%b result=%h, required 000 / 0000000e",
                  {busy, valid, stall}, result);
      end
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) seen++;
      end
      tests++;
      if (seen !== 0) begin fails++; $display("FAIL flush_novalid: %0d valid cycles, required 0", seen); end
   endtask

   task automatic test_async_reset();
      logic [31:0] r; int lat; bit sok;
      @(negedge clk);
      op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, valid, stall} !== 3'b000 || result !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: busy/valid/stall=%b result=%h, required 000 / 00000000",
                  {busy, valid, stall}, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'b101, 32'd100, 32'd7, r, lat, sok);
      tests++;
      if (r !== 32'd14 || lat !== 33) begin
         fails++;
         $display("FAIL post_reset_op: got %h lat %0d, required 0000000e lat 33", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mul_high();
      test_div();
      test_special();
      test_busy_start();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
